regfile_dump_reader: RTL

//  Sequential reader for the CPU register file. It walks a contiguous index range
//  [first_idx..last_idx] through one asynchronous read port (rs -> rv) and streams

---
 rtl/regfile_dump_reader.sv | 79 +++++++
 1 files changed

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks a register-file index range and streams (index, data) pairs
// Each entry takes a READ cycle then a SEND cycle; checksum sums accepted data.
module regfile_dump_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_idx,
  input  logic [ADDR_W-1:0] last_idx,
  output logic [ADDR_W-1:0] rf_rs,
  input  logic [DATA_W-1:0] rf_rv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] end_idx;

  assign rf_rs = cur;
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= '0;
      end_idx   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      checksum  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cur      <= first_idx;
            end_idx  <= last_idx;
            checksum <= '0;
            state    <= READ;
          end
        end
        READ: begin
          out_data  <= rf_rv;
          out_idx   <= cur;
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            checksum  <= checksum + out_data;
            out_valid <= 1'b0;
            // cur wraps naturally at the top index, so first > last walks through 0
            if (cur != end_idx) begin
              cur   <= cur + 1'b1;
              state <= READ;
            end else begin
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
